// File: rtl/rv_decode_pkg.sv
// ---------------------------------------------------------------------------
// rv_decode_pkg
// Shared constants and types for the RISC-V decode stage: base opcodes,
// the ECALL/EBREAK encodings, the immediate-format enum and the packed
// decoded-field payload carried through the skid buffer.
// No ports (package).
// ---------------------------------------------------------------------------
package rv_decode_pkg;

   localparam int unsigned INSTR_W = 32;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [INSTR_W-1:0] INSTR_ECALL  = 32'h0000_0073;
   localparam logic [INSTR_W-1:0] INSTR_EBREAK = 32'h0010_0073;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_type_e;

   // XLEN-independent part of a decoded entry
   typedef struct packed {
      logic [6:0] opcode;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [2:0] funct3;
      logic [6:0] funct7;
      imm_type_e  imm_type;
      logic       illegal;
   } dec_fields_t;

endpackage

// File: rtl/rv_decode_if.sv
// ---------------------------------------------------------------------------
// rv_decode_if
// Fetch-side and execute-side handshake bundle of the decode stage.
//   flush                      : squash buffered entries
//   in_valid/in_ready/in_instr/in_pc : fetch -> decode
//   out_valid/out_ready/out_*  : decode -> execute
// Modports: master = environment (fetch + execute), slave = decode stage.
// ---------------------------------------------------------------------------
interface rv_decode_if #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned PC_W = 32
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [PC_W-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic [PC_W-1:0] out_pc;
   logic [6:0]      out_opcode;
   logic [4:0]      out_rd;
   logic [4:0]      out_rs1;
   logic [4:0]      out_rs2;
   logic [2:0]      out_funct3;
   logic [6:0]      out_funct7;
   logic [XLEN-1:0] out_imm;
   logic [2:0]      out_imm_type;
   logic            out_illegal;

   modport master (
      output flush, in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
             out_funct3, out_funct7, out_imm, out_imm_type, out_illegal
   );

   modport slave (
      input  flush, in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
             out_funct3, out_funct7, out_imm, out_imm_type, out_illegal
   );
endinterface

// File: rtl/rv_decode_comb.sv
// ---------------------------------------------------------------------------
// rv_decode_comb
// Pure combinational RV32/RV64 base decode: field extraction, immediate
// generation with sign extension to XLEN, and illegal-encoding detection.
// Optional macro RV_DECODE_M_EN: when defined, OP with funct7=0000001
// (M extension) is accepted as legal.
//   instr_i    : raw 32-bit instruction
//   fields_c_o : decoded fields, imm format, illegal flag
//   imm_c_o    : sign-extended immediate
// ---------------------------------------------------------------------------
module rv_decode_comb
   import rv_decode_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [INSTR_W-1:0] instr_i,
   output dec_fields_t        fields_c_o,
   output logic [XLEN-1:0]    imm_c_o
);

   logic [6:0]         opcode;
   logic [2:0]         f3;
   logic [6:0]         f7;
   logic               s;
   logic [INSTR_W-1:0] imm32;
   imm_type_e          imm_type;
   logic               illegal;

   assign opcode = instr_i[6:0];
   assign f3     = instr_i[14:12];
   assign f7     = instr_i[31:25];
   assign s      = instr_i[31];

   // Immediate format and 32-bit signed immediate
   always_comb begin
      imm32    = '0;
      imm_type = IMM_NONE;
      case (opcode)
         OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
            imm32    = {{20{s}}, instr_i[31:20]};
            imm_type = IMM_I;
         end
         OPC_STORE: begin
            imm32    = {{20{s}}, instr_i[31:25], instr_i[11:7]};
            imm_type = IMM_S;
         end
         OPC_BRANCH: begin
            imm32    = {{19{s}}, s, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
            imm_type = IMM_B;
         end
         OPC_LUI, OPC_AUIPC: begin
            imm32    = {instr_i[31:12], 12'b0};
            imm_type = IMM_U;
         end
         OPC_JAL: begin
            imm32    = {{11{s}}, s, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
            imm_type = IMM_J;
         end
         default: begin
            imm32    = '0;
            imm_type = IMM_NONE;
         end
      endcase
   end

   // Illegal-encoding detection
   always_comb begin
      illegal = 1'b0;
      case (opcode)
         OPC_OP: begin
            if (f7 == 7'b0000000)      illegal = 1'b0;
            else if (f7 == 7'b0100000) illegal = !((f3 == 3'b000) || (f3 == 3'b101));
`ifdef RV_DECODE_M_EN
            else if (f7 == 7'b0000001) illegal = 1'b0;
`endif
            else                       illegal = 1'b1;
         end
         OPC_OP_IMM: begin
            // only shifts constrain funct7; SRAI (0100000) is valid, SLLI is not
            if ((f3 == 3'b001) || (f3 == 3'b101)) begin
               if (f7 == 7'b0100000) illegal = (f3 == 3'b001);
               else                  illegal = (f7 != 7'b0000000);
            end
         end
         OPC_LOAD:     illegal = (f3 == 3'b111) ||
                                 ((XLEN == 32) && ((f3 == 3'b011) || (f3 == 3'b110)));
         OPC_STORE:    illegal = f3[2] || ((XLEN == 32) && (f3 == 3'b011));
         OPC_BRANCH:   illegal = (f3 == 3'b010) || (f3 == 3'b011);
         OPC_JALR:     illegal = (f3 != 3'b000);
         OPC_SYSTEM:   illegal = (instr_i != INSTR_ECALL) && (instr_i != INSTR_EBREAK);
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_MISC_MEM: illegal = 1'b0;
         default:      illegal = 1'b1;
      endcase
      if ((instr_i == '0) || (instr_i == '1)) illegal = 1'b1;
   end

   assign imm_c_o             = XLEN'($signed(imm32));
   assign fields_c_o.opcode   = opcode;
   assign fields_c_o.rd       = instr_i[11:7];
   assign fields_c_o.rs1      = instr_i[19:15];
   assign fields_c_o.rs2      = instr_i[24:20];
   assign fields_c_o.funct3   = f3;
   assign fields_c_o.funct7   = f7;
   assign fields_c_o.imm_type = imm_type;
   assign fields_c_o.illegal  = illegal;

endmodule

// File: rtl/rv_decode_stage.sv
// ---------------------------------------------------------------------------
// rv_decode_stage
// Registered decode stage between fetch and execute with a 2-entry skid
// buffer (registered in_ready, full throughput) and flush on redirect.
// Optional macro RV_DECODE_M_EN (see rv_decode_comb) enables M-extension
// OP encodings as legal.
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : rv_decode_if.slave (flush, in_* handshake, out_* handshake)
// ---------------------------------------------------------------------------
module rv_decode_stage
   import rv_decode_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned PC_W = 32
) (
   input  logic     clk,
   input  logic     rst_n,
   rv_decode_if.slave bus
);

   typedef struct packed {
      dec_fields_t     f;
      logic [XLEN-1:0] imm;
      logic [PC_W-1:0] pc;
   } entry_t;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   logic [1:0]      state_q, state_d;
   entry_t          head_q, head_d, tail_q, tail_d;
   entry_t          dec_entry;
   dec_fields_t     dec_fields;
   logic [XLEN-1:0] dec_imm;
   logic            in_ready_q, out_valid_q;
   logic            push, pop;

   rv_decode_comb #(.XLEN(XLEN)) u_comb (
      .instr_i    (bus.in_instr),
      .fields_c_o (dec_fields),
      .imm_c_o    (dec_imm)
   );

   assign dec_entry = '{f: dec_fields, imm: dec_imm, pc: bus.in_pc};
   assign push      = bus.in_valid && in_ready_q;
   assign pop       = out_valid_q && bus.out_ready;

   // Occupancy FSM; head is the visible entry, tail only used when FULL
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      if (bus.flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (push) begin
                  head_d  = dec_entry;
                  state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               if (push && pop) begin
                  head_d = dec_entry;
               end else if (push) begin
                  tail_d  = dec_entry;
                  state_d = ST_FULL;
               end else if (pop) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (pop) begin
                  head_d  = tail_q;
                  state_d = ST_ONE;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   // State, payload and handshake registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_EMPTY;
         head_q      <= '0;
         tail_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         in_ready_q  <= (state_d != ST_FULL);
         out_valid_q <= (state_d != ST_EMPTY);
      end
   end

   assign bus.in_ready     = in_ready_q;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_pc       = head_q.pc;
   assign bus.out_opcode   = head_q.f.opcode;
   assign bus.out_rd       = head_q.f.rd;
   assign bus.out_rs1      = head_q.f.rs1;
   assign bus.out_rs2      = head_q.f.rs2;
   assign bus.out_funct3   = head_q.f.funct3;
   assign bus.out_funct7   = head_q.f.funct7;
   assign bus.out_imm      = head_q.imm;
   assign bus.out_imm_type = head_q.f.imm_type;
   assign bus.out_illegal  = head_q.f.illegal;

endmodule
